// File: rtl/ro_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ro_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StMeasure,
        StDone
    } ro_state_e;

    localparam int unsigned SETTLE_CYCLES = 4;
    localparam int unsigned SYNC_STAGES   = 2;

endpackage

// File: rtl/ro_edge_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input with a one-cycle rise pulse.
module ro_edge_sync
    import ro_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Counts synchronized ring-oscillator rising edges over a fixed gate window of clk cycles.
module ro_freq_meter
    import ro_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ro_clk,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             overflow
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ro_state_e          state_q, state_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               ro_rise;

    ro_edge_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (ro_clk),
        .rise     (ro_rise)
    );

    always_comb begin
        state_d    = state_q;
        set_cnt_d  = set_cnt_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StSettle;
                    set_cnt_d = SET_W'(SETTLE_CYCLES - 1);
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    if (set_cnt_q == '0) begin
                        state_d    = StMeasure;
                        gate_cnt_d = GATE_W'(GATE_CYCLES - 1);
                    end else begin
                        set_cnt_d = set_cnt_q - SET_W'(1);
                    end
                end
            end
            StMeasure: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    // Edges beyond the ceiling are dropped and flagged.
                    if (ro_rise) begin
                        if (edge_cnt_q == CNT_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            edge_cnt_d = edge_cnt_q + CNT_W'(1);
                        end
                    end
                    if (gate_cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        gate_cnt_d = gate_cnt_q - GATE_W'(1);
                    end
                end
            end
            StDone: begin
                result_d   = edge_cnt_q;
                overflow_d = sat_q;
                valid_d    = 1'b1;
                done_d     = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            set_cnt_q  <= '0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_cnt_q  <= set_cnt_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Randomized scoreboard bench for ro_freq_meter driven by a pre-planned ro_clk waveform.
module tb_ro_freq_meter;

    localparam int G      = 100;
    localparam int W      = 4;
    localparam int MAXC   = (1 << W) - 1;
    localparam int WAVE_N = 32768;

    logic         clk = 1'b0;
    logic         reset, ro_clk, start, abort;
    logic         busy, done, result_valid, overflow;
    logic [W-1:0] result;

    ro_freq_meter #(
        .GATE_CYCLES(G),
        .CNT_W      (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ro_clk       (ro_clk),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_valid (result_valid),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // cyc = number of rising clk edges so far; wave[n] is the level driven after edge n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit wave [WAVE_N];
    always @(negedge clk) ro_clk = wave[cyc];

    typedef struct {
        int done_cyc;
        int res;
        int ov;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   held_res = 0;
    int   held_ov = 0;
    int   held_valid = 0;
    int   s_cur = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A level change driven after edge n is counted on edge n+3; the window of counted edges
    // is the G edges after the four settle cycles.
    function automatic exp_t model(input int s);
        exp_t e;
        int   edges = 0;
        for (int n = s + 2; n <= s + 1 + G; n++)
            if (wave[n] && !wave[n-1]) edges++;
        e.done_cyc = s + 5 + G;
        e.res      = (edges > MAXC) ? MAXC : edges;
        e.ov       = (edges > MAXC) ? 1 : 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", int'(done), 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("result", int'(result), e.res);
                chk("overflow", int'(overflow), e.ov);
                chk("result_valid", int'(result_valid), 1);
                chk("busy_at_done", int'(busy), 0);
                held_res   = e.res;
                held_ov    = e.ov;
                held_valid = 1;
            end
        end
    end

    task automatic wait_until(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // fill: 0 keep random wave, 1 period 10, 2 period 5, 3 held low, 4 held high
    task automatic do_start(input int fill);
        s_cur = cyc + 1;
        for (int n = s_cur; n <= s_cur + G + 10; n++) begin
            case (fill)
                1: wave[n] = ((n - s_cur) % 10) >= 5;
                2: wave[n] = ((n - s_cur) % 5) >= 3;
                3: wave[n] = 1'b0;
                4: wave[n] = 1'b1;
                default: ;
            endcase
        end
        sb.push_back(model(s_cur));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic finish_meas();
        wait_until(s_cur + 5 + G);
    endtask

    task automatic pulse_abort_at(input int k);
        exp_t dropped;
        wait_until(k);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        dropped = sb.pop_back();
        chk("busy_after_abort", int'(busy), 0);
        chk("result_held", int'(result), held_res);
        chk("overflow_held", int'(overflow), held_ov);
        chk("valid_held", int'(result_valid), held_valid);
    endtask

    task automatic pulse_start_at(input int k);
        wait_until(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_valid"}, int'(result_valid), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        int n = 0;
        int mode, len, hi, lo, end_n, r, s;
        exp_t dropped;

        while (n < WAVE_N) begin
            mode  = $urandom_range(0, 3);
            len   = $urandom_range(150, 400);
            end_n = n + len;
            while (n < end_n && n < WAVE_N) begin
                if (mode == 0) begin
                    wave[n++] = 1'b0;
                end else if (mode == 1) begin
                    wave[n++] = 1'b1;
                end else begin
                    hi = (mode == 2) ? $urandom_range(2, 8) : 3;
                    lo = (mode == 2) ? $urandom_range(2, 8) : 2;
                    if (hi + lo < 5) lo = 5 - hi;
                    for (int k = 0; k < hi && n < WAVE_N; k++) wave[n++] = 1'b1;
                    for (int k = 0; k < lo && n < WAVE_N; k++) wave[n++] = 1'b0;
                end
            end
        end

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Saturation, then nominal so the abort below holds 10/0.
        do_start(2);
        finish_meas();
        do_start(1);
        finish_meas();

        // Abort in the 20th measure cycle.
        do_start(0);
        pulse_abort_at(s_cur + 23);
        wait_until(s_cur + G + 8);

        // Extra starts in settle, measure and done are ignored.
        do_start(0);
        pulse_start_at(s_cur + 1);
        pulse_start_at(s_cur + 40);
        pulse_start_at(s_cur + 4 + G);
        finish_meas();
        do_start(1);
        finish_meas();

        // One-cycle reset in the middle of a measurement.
        do_start(0);
        wait_until(s_cur + 30);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dropped = sb.pop_back();
        held_res   = 0;
        held_ov    = 0;
        held_valid = 0;
        check_reset_outputs("midreset");
        wait_until(s_cur + G + 8);
        do_start(1);
        finish_meas();

        do_start(3);
        finish_meas();
        do_start(4);
        finish_meas();

        for (int i = 0; i < 14; i++) begin
            do_start(0);
            s = s_cur;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                pulse_abort_at($urandom_range(s, s + 3 + G));
                wait_until(s + G + 8);
            end else begin
                if (r == 1) begin
                    // Abort in DONE must not stop the latch.
                    wait_until(s + 4 + G);
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                end else if (r <= 4) begin
                    pulse_start_at($urandom_range(s, s + 4 + G));
                end
                finish_meas();
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (G + 10) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
